// File: rtl/a2g_ctrl_rx_capture.sv
// Serial readback capture for the a2g control path: deserialises 32-bit frames into a
// small first-word-fall-through FIFO and publishes a registered status word and head word.
module a2g_ctrl_rx_capture #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned FIFO_AW     = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        ser_sclk,
  input  logic        ser_sdata,
  input  logic        ser_cs_n,
  input  logic        pop_toggle,
  input  logic        clr_toggle,
  output logic [31:0] rx_status,
  output logic [31:0] rx_data
);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sdata_sync_q, cs_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_rise, cs_rise, cs_fall, sdata_s;

  state_e           state_q, state_d;
  logic [31:0]      shift_q, shift_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic             commit, ferr_set;

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0] count_q, count_d;
  logic             full, empty, pop_fire, push_ok, ovf_set;

  logic             init_q, pop_prev_q, clr_prev_q, pop_req_q, clr_det;
  logic             ovf_q, ferr_q;
  logic [7:0]       frames_ok_q;
  logic [31:0]      status_q, data_q;

  // cs_n synchroniser resets low so a frame in flight at reset is never picked up mid-way;
  // a genuine high-then-low sequence is needed before the next frame starts.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      sclk_sync_q  <= '0;
      sdata_sync_q <= '0;
      cs_sync_q    <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], ser_sclk};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], ser_sdata};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], ser_cs_n};
      sclk_prev_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q    <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
  assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
  assign sdata_s   = sdata_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    commit    = 1'b0;
    ferr_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (cs_rise) begin
          if (bit_cnt_q == 6'd32) begin
            state_d = StCommit;
          end else begin
            state_d  = StIdle;
            ferr_set = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[30:0], sdata_s};
          // Saturate at 33 so a long burst of extra clocks cannot wrap back to 32.
          if (bit_cnt_q != 6'd33) bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd32) ferr_set = 1'b1;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign full     = (count_q == DepthCnt);
  assign empty    = (count_q == '0);
  assign pop_fire = pop_req_q & ~empty;
  // A pop in the commit cycle frees a slot, so a full FIFO still accepts the word.
  assign push_ok  = commit & (~full | pop_fire);
  assign ovf_set  = commit & full & ~pop_fire;
  assign clr_det  = init_q & (clr_toggle != clr_prev_q);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_fire) count_d = count_q + 1'b1;
    else if (!push_ok && pop_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge user_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      init_q      <= 1'b0;
      pop_prev_q  <= 1'b0;
      clr_prev_q  <= 1'b0;
      pop_req_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
      frames_ok_q <= '0;
      status_q    <= 32'h1000_0000;
      data_q      <= '0;
    end else begin
      init_q      <= 1'b1;
      pop_prev_q  <= pop_toggle;
      clr_prev_q  <= clr_toggle;
      pop_req_q   <= init_q & (pop_toggle != pop_prev_q);
      if (push_ok) begin
        wr_ptr_q    <= wr_ptr_q + 1'b1;
        frames_ok_q <= frames_ok_q + 8'd1;
      end
      if (pop_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      ovf_q       <= ovf_set | (ovf_q & ~clr_det);
      ferr_q      <= ferr_set | (ferr_q & ~clr_det);
      status_q    <= {full, ovf_q, ferr_q, empty, 4'(count_q), frames_ok_q, 16'h0000};
      data_q      <= empty ? 32'h0 : mem_q[rd_ptr_q];
    end
  end

  assign rx_status = status_q;
  assign rx_data   = data_q;

endmodule

// File: tb/tb_a2g_ctrl_rx_capture.sv
// Directed bench for a2g_ctrl_rx_capture: drives serial frames and toggles, checks the
// registered status and head words against hand-computed values.
module tb_a2g_ctrl_rx_capture;

  logic        user_clk = 1'b0;
  logic        user_rst_n;
  logic        ser_sclk, ser_sdata, ser_cs_n;
  logic        pop_toggle, clr_toggle;
  logic [31:0] rx_status, rx_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 user_clk = ~user_clk;

  a2g_ctrl_rx_capture #(
    .FIFO_DEPTH (4),
    .FIFO_AW    (2),
    .SYNC_STAGES(2)
  ) dut (
    .user_clk  (user_clk),
    .user_rst_n(user_rst_n),
    .ser_sclk  (ser_sclk),
    .ser_sdata (ser_sdata),
    .ser_cs_n  (ser_cs_n),
    .pop_toggle(pop_toggle),
    .clr_toggle(clr_toggle),
    .rx_status (rx_status),
    .rx_data   (rx_data)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    user_rst_n = 1'b0;
    tick(3);
    user_rst_n = 1'b1;
    tick(3);
  endtask

  task automatic do_pop();
    pop_toggle = ~pop_toggle;
    tick(5);
  endtask

  task automatic do_clr();
    clr_toggle = ~clr_toggle;
    tick(5);
  endtask

  // Sends nbits MSB-first; bits beyond 32 are zeros. early_pop lands a pop in the commit cycle.
  task automatic send_frame(input logic [31:0] w, input int nbits, input bit early_pop);
    ser_cs_n = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      ser_sdata = (i < 32) ? w[31-i] : 1'b0;
      ser_sclk  = 1'b0;
      tick(4);
      ser_sclk  = 1'b1;
      tick(4);
    end
    ser_sclk = 1'b0;
    tick(4);
    ser_cs_n = 1'b1;
    if (early_pop) begin
      tick(2);
      pop_toggle = ~pop_toggle;
      tick(10);
    end else begin
      tick(12);
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic [31:0] w;
    user_rst_n = 1'b0;
    ser_sclk   = 1'b0;
    ser_sdata  = 1'b0;
    ser_cs_n   = 1'b1;
    pop_toggle = 1'b0;
    clr_toggle = 1'b0;
    tick(3);
    user_rst_n = 1'b1;
    tick(3);

    // Reset state and a single good frame
    check("reset_status", rx_status, 32'h1000_0000);
    check("reset_data", rx_data, 32'h0);
    send_frame(32'hDEAD_BEEF, 32, 1'b0);
    check("single_data", rx_data, 32'hDEAD_BEEF);
    check("single_status", rx_status, 32'h0101_0000);
    do_pop();
    check("single_pop_data", rx_data, 32'h0);
    check("single_pop_status", rx_status, 32'h1001_0000);

    // Fill, overflow, drain
    do_reset();
    for (int i = 1; i <= 4; i++) send_frame(32'(i), 32, 1'b0);
    check("full_status", rx_status, 32'h8404_0000);
    check("full_head", rx_data, 32'h1);
    send_frame(32'h5, 32, 1'b0);
    check("overflow_status", rx_status, 32'hC404_0000);
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", rx_data, 32'(i));
      do_pop();
    end
    check("drained_data", rx_data, 32'h0);
    check("drained_status", rx_status, 32'h5004_0000);
    do_clr();
    check("ovf_clear", rx_status, 32'h1004_0000);

    // Short and long frames
    send_frame(32'hFFFF_FFFF, 31, 1'b0);
    check("short_frame", rx_status, 32'h3004_0000);
    send_frame(32'hFFFF_FFFF, 33, 1'b0);
    check("long_frame", rx_status, 32'h3004_0000);
    check("long_frame_data", rx_data, 32'h0);
    do_clr();
    check("ferr_clear", rx_status, 32'h1004_0000);

    // Pop coinciding with commit while full
    for (int i = 1; i <= 4; i++) send_frame(32'(i << 4), 32, 1'b0);
    check("refill_status", rx_status, 32'h8408_0000);
    send_frame(32'hA5A5_A5A5, 32, 1'b1);
    check("push_pop_status", rx_status, 32'h8409_0000);
    for (int i = 2; i <= 4; i++) begin
      check("push_pop_drain", rx_data, 32'(i << 4));
      do_pop();
    end
    check("push_pop_last", rx_data, 32'hA5A5_A5A5);
    do_pop();
    check("push_pop_empty", rx_status, 32'h1009_0000);

    // Reset in the middle of a frame
    ser_cs_n = 1'b0;
    tick(8);
    for (int i = 0; i < 16; i++) begin
      ser_sdata = i[0];
      ser_sclk  = 1'b0;
      tick(4);
      ser_sclk  = 1'b1;
      tick(4);
    end
    do_reset();
    check("midreset_status", rx_status, 32'h1000_0000);
    ser_sclk = 1'b0;
    tick(8);
    ser_cs_n = 1'b1;
    tick(12);
    check("midreset_idle", rx_status, 32'h1000_0000);
    send_frame(32'h1234_5678, 32, 1'b0);
    check("midreset_data", rx_data, 32'h1234_5678);
    check("midreset_frame", rx_status, 32'h0101_0000);
    do_pop();
    check("midreset_one_word", rx_status, 32'h1001_0000);

    // Empty pop, then frames_ok wrap
    do_reset();
    do_pop();
    check("empty_pop_status", rx_status, 32'h1000_0000);
    check("empty_pop_data", rx_data, 32'h0);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      w = {b, ~b, b, 8'h3C};
      send_frame(w, 32, 1'b0);
      check("wrap_data", rx_data, w);
      do_pop();
      if (i == 254) check("wrap_ff", rx_status, 32'h10FF_0000);
    end
    check("wrap_zero", rx_status, 32'h1000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
